// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter family.
package uart_tx_arbiter_pkg;

  localparam int MAX_REQ = 8;
  localparam int PTR_W   = $clog2(MAX_REQ);

  typedef enum logic [2:0] {
    IDLE,
    GRANTED,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

  // Next round-robin starting index after owner ptr, wrapping at n requesters.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                              input int unsigned      n);
    int unsigned nxt;
    nxt = 32'(ptr) + 32'd1;
    if (nxt >= n) nxt = 0;
    return nxt[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set valid bit at or after ptr_i,
// wrapping modulo NUM_REQ. Returns one-hot pick, its index and an any flag.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  // Walk the requesters in priority order starting at ptr_i; first hit wins.
  always_comb begin : search
    int unsigned slot;
    slot   = 0;
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = (32'(ptr_i) + 32'(k)) % 32'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_o && (slot == 32'(i)) && valid_i[i]) begin
          any_o     = 1'b1;
          pick_o[i] = 1'b1;
          idx_o     = PTR_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one byte UART serializer
// between NUM_REQ valid/ready/last byte streams.
// Optional: define UART_TX_ARBITER_HOLD_TIMEOUT_EN to revoke a grant whose
// owner has stalled for HOLD_TIMEOUT cycles (adds the hold_timeout output).
//
// state     | meaning
// IDLE      | no owner; arbitrate among valid requesters
// GRANTED   | owner selected; wait for owner byte and idle serializer
// START     | start/ready pulse cycle for the accepted byte
// WAIT_BUSY | wait for the serializer to report busy
// WAIT_DONE | frame in flight; release on last byte or take next byte
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CNT_W        = 16,
  parameter int HOLD_TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_last,
  input  logic [7:0]         req_data [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic [CNT_W-1:0]   bytes_sent
`ifdef UART_TX_ARBITER_HOLD_TIMEOUT_EN
  ,
  output logic               hold_timeout
`endif
);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PTR_W-1:0]   owner_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic               last_q;
  logic               tx_start_q;
  logic [7:0]         tx_data_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [CNT_W-1:0]   bytes_q;

  logic [NUM_REQ-1:0] pick_d;
  logic [PTR_W-1:0]   pick_idx_d;
  logic               pick_any_d;

  logic               owner_valid;
  logic               owner_last;
  logic [7:0]         owner_data;

`ifdef UART_TX_ARBITER_HOLD_TIMEOUT_EN
  localparam int TO_W = (HOLD_TIMEOUT < 2) ? 1 : $clog2(HOLD_TIMEOUT);
  logic [TO_W-1:0] stall_q;
  logic            hold_timeout_q;
  assign hold_timeout = hold_timeout_q;
`endif

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .pick_o  (pick_d),
    .idx_o   (pick_idx_d),
    .any_o   (pick_any_d)
  );

  // Owner's stream, selected with the one-hot grant so no index arithmetic is needed.
  always_comb begin
    owner_valid = |(req_valid & grant_q);
    owner_last  = |(req_last & grant_q);
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner_data = owner_data | req_data[i];
    end
  end

  // Arbitration and serializer handshake FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      last_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      req_ready_q <= '0;
      bytes_q     <= '0;
`ifdef UART_TX_ARBITER_HOLD_TIMEOUT_EN
      stall_q        <= '0;
      hold_timeout_q <= 1'b0;
`endif
    end else begin
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any_d) begin
            grant_q <= pick_d;
            owner_q <= pick_idx_d;
            state_q <= GRANTED;
`ifdef UART_TX_ARBITER_HOLD_TIMEOUT_EN
            stall_q <= '0;
`endif
          end
        end
        GRANTED: begin
          if (owner_valid && !tx_busy) begin
            tx_data_q   <= owner_data;
            tx_start_q  <= 1'b1;
            req_ready_q <= grant_q;
            last_q      <= owner_last;
            bytes_q     <= bytes_q + CNT_W'(1);
            state_q     <= START;
`ifdef UART_TX_ARBITER_HOLD_TIMEOUT_EN
            stall_q     <= '0;
          end else if (!owner_valid) begin
            if (stall_q == TO_W'(HOLD_TIMEOUT - 1)) begin
              grant_q        <= '0;
              rr_ptr_q       <= rr_next(owner_q, NUM_REQ);
              hold_timeout_q <= 1'b1;
              stall_q        <= '0;
              state_q        <= IDLE;
            end else begin
              stall_q <= stall_q + TO_W'(1);
            end
`endif
          end
        end
        START: begin
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_q) begin
              grant_q  <= '0;
              rr_ptr_q <= rr_next(owner_q, NUM_REQ);
              state_q  <= IDLE;
            end else begin
              state_q <= GRANTED;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign req_ready  = req_ready_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign bytes_sent = bytes_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues feed the
// DUT, expected bytes (with owner id) are queued in service order and popped
// on every tx_start. Built with or without UART_TX_ARBITER_HOLD_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int CW    = 4;
  localparam int FRAME = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [7:0]      req_data [NR];
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   grant;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy = 1'b0;
  logic [CW-1:0]   bytes_sent;
`ifdef UART_TX_ARBITER_HOLD_TIMEOUT_EN
  logic            hold_timeout;
`endif

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .CNT_W        (CW),
    .HOLD_TIMEOUT (50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .grant      (grant),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .bytes_sent (bytes_sent)
`ifdef UART_TX_ARBITER_HOLD_TIMEOUT_EN
    ,
    .hold_timeout (hold_timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb [$];
  logic [8:0] pend [NR][$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         starts  = 0;
  int         bcnt    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_byte(input int id, input logic [7:0] data, input logic last);
    exp_t e;
    pend[id].push_back({last, data});
    e.id   = 2'(id);
    e.data = data;
    sb.push_back(e);
  endtask

  function automatic bit all_pend_empty();
    for (int i = 0; i < NR; i++) if (pend[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_quiet(input int budget, input string tag);
    int c = 0;
    while ((sb.size() != 0 || grant != '0 || !all_pend_empty()) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(c < budget), 32'd1);
  endtask

  task automatic wait_grant(input logic [NR-1:0] g, input int budget, input string tag);
    int c = 0;
    while (grant != g && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(grant), 32'(g));
  endtask

  // Requester models: present the head of each queue, pop on req_ready.
  initial begin
    req_valid = '0;
    req_last  = '0;
    for (int i = 0; i < NR; i++) req_data[i] = 8'h00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && pend[i].size() != 0) void'(pend[i].pop_front());
        if (pend[i].size() != 0) begin
          req_valid[i] = 1'b1;
          req_last[i]  = pend[i][0][8];
          req_data[i]  = pend[i][0][7:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Serializer model: busy from the cycle after tx_start for FRAME cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) bcnt = FRAME;
      else if (bcnt > 0) bcnt = bcnt - 1;
      tx_busy = (bcnt != 0);
    end
  end

  // Output monitor: every start pulse consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        starts++;
        if (sb.size() == 0) begin
          check("sb_unexpected_start", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("owner", 32'(grant), 32'(1) << e.id);
          check("ready_vs_grant", 32'(req_ready), 32'(grant));
        end
      end
    end
  end

  initial begin
    int  gap;
    bit  early;
    int  c;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_bytes", 32'(bytes_sent), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single message "Hi" from requester 0
    starts = 0;
    push_byte(0, 8'h48, 1'b0);
    push_byte(0, 8'h69, 1'b1);
    wait_quiet(400, "hi_timeout");
    check("hi_bytes", 32'(bytes_sent), 32'd2);
    check("hi_starts", 32'(starts), 32'd2);
    check("hi_grant_idle", 32'(grant), 32'd0);
    check("hi_tx_data_hold", 32'(tx_data), 32'h69);

    // Contention from reset: 1 before 2, one idle cycle between
    rst_n = 1'b0;
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h12, 1'b1);
    push_byte(2, 8'h21, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_grant(4'b0010, 20, "cont_first_grant");
    wait_grant(4'b0000, 200, "cont_release");
    gap = 0;
    while (grant == '0 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("cont_idle_gap", 32'(gap), 32'd1);
    check("cont_second_grant", 32'(grant), 32'b0100);
    wait_quiet(400, "cont_timeout");
    check("cont_bytes", 32'(bytes_sent), 32'd3);

    // rr_ptr is now 3: simultaneous 0 and 3 -> 3 first
    push_byte(3, 8'h30, 1'b1);
    push_byte(0, 8'h03, 1'b1);
    wait_quiet(400, "wrap_timeout");

    // No interleave: 3 arrives mid-message of 0
    push_byte(0, 8'hA0, 1'b0);
    push_byte(0, 8'hA1, 1'b0);
    push_byte(0, 8'hA2, 1'b1);
    wait_grant(4'b0001, 20, "noint_grant0");
    push_byte(3, 8'hB0, 1'b1);
    early = 1'b0;
    c = 0;
    while (grant == 4'b0001 && c < 400) begin
      @(negedge clk);
      if (req_ready[3]) early = 1'b1;
      c++;
    end
    check("noint_ready3", 32'(early), 32'd0);
    wait_quiet(400, "noint_timeout");

    // Move rr_ptr to 2, then reset mid-message of requester 2
    push_byte(1, 8'h51, 1'b1);
    wait_quiet(400, "pre_rst_timeout");
    push_byte(2, 8'h61, 1'b0);
    push_byte(2, 8'h62, 1'b0);
    push_byte(2, 8'h63, 1'b1);
    c = 0;
    while (!(tx_busy && grant == 4'b0100) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("midrst_reach_busy", 32'(c < 100), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    pend[2].delete();
    @(negedge clk);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_bytes", 32'(bytes_sent), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    push_byte(1, 8'h71, 1'b1);
    push_byte(2, 8'h61, 1'b0);
    push_byte(2, 8'h62, 1'b0);
    push_byte(2, 8'h63, 1'b1);
    wait_quiet(600, "restart_timeout");
    check("restart_bytes", 32'(bytes_sent), 32'd4);

    // Stalled owner
    push_byte(0, 8'hC0, 1'b0);
    c = 0;
    while (!req_ready[0] && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("stall_accept", 32'(c < 50), 32'd1);
`ifdef UART_TX_ARBITER_HOLD_TIMEOUT_EN
    repeat (40) @(negedge clk);
    check("stall_held_early", 32'(grant), 32'b0001);
    check("stall_flag_early", 32'(hold_timeout), 32'd0);
    repeat (40) @(negedge clk);
    check("stall_revoked", 32'(grant), 32'd0);
    check("stall_flag", 32'(hold_timeout), 32'd1);
`else
    repeat (1000) @(negedge clk);
    check("stall_held", 32'(grant), 32'b0001);
`endif
    push_byte(0, 8'hC1, 1'b1);
    wait_quiet(400, "stall_end_timeout");
    check("stall_bytes", 32'(bytes_sent), 32'd6);

    // Counter wrap: 17 bytes into a 4-bit counter
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) push_byte(1, 8'(8'h80 + i), (i == 16));
    wait_quiet(1500, "wrap17_timeout");
    check("wrap17_bytes", 32'(bytes_sent), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-level UART transmitter (start/busy handshake) between NUM_REQ requesters.
- Each requester streams a message with a valid/ready/last byte interface.
- Arbitration is round-robin at message granularity. A grant is held until the byte flagged last has been fully shifted out, so messages never interleave on the line.
- Sits between producers (text/memory readers, debug dumpers) and the uart_tx-style serializer.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- CNT_W, 16, width of the bytes_sent statistic counter.
- HOLD_TIMEOUT, 1000000, idle cycles before a stalled grant is revoked (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  byte available from requester i.
- req_last  in  NUM_REQ  byte on req_data[i] is the final byte of its message.
- req_data  in  [NUM_REQ][8]  unpacked array of byte values, one per requester.
- req_ready  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- tx_start  out  1  one-cycle start pulse to the serializer.
- tx_data  out  8  byte to the serializer; held stable until the next accept.
- tx_busy  in  1  serializer busy. Rises the cycle after tx_start and falls at the stop bit.
- bytes_sent  out  CNT_W  count of accepted bytes.

Behaviour:
- Reset (rst_n=0 at a posedge): the following all clear.
  - State goes to IDLE.
  - grant, req_ready, tx_start, tx_data, bytes_sent and rr_ptr all go to 0.
  - A serializer frame already in flight is not aborted (the serializer has no reset). The arbiter just stops driving it.
- State IDLE:
  - If any req_valid bit is set, pick the first set index searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register the one-hot grant and go to GRANTED.
  - Latency: grant is visible 1 cycle after req_valid is sampled.
- State GRANTED (owner g):
  - When req_valid[g]=1 and tx_busy=0, in one cycle: tx_data<=req_data[g], tx_start<=1, req_ready[g]<=1, last_q<=req_last[g], bytes_sent<=bytes_sent+1.
  - Then go to START.
  - Otherwise stay in GRANTED.
- State START: tx_start<=0 and req_ready<=0, then go to WAIT_BUSY.
- State WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
- State WAIT_DONE: stay until tx_busy=0.
  - If last_q=1: grant<=0, rr_ptr<=(g+1) mod NUM_REQ, go to IDLE.
  - Otherwise go back to GRANTED.
- Handshake: a requester holds req_data/req_last stable while req_valid is high until it sees req_ready. req_ready and tx_start pulse in the same cycle.
- Non-granted requesters: never see req_ready; their valid bits only affect the next arbitration.
- Throughput: at most one accepted byte per serializer frame. The next tx_start can land during the previous frame's stop bit.
- Message boundary: there is always at least one IDLE cycle between messages, even when other requesters are waiting.
- bytes_sent wraps modulo 2^CNT_W.
- Stall: if the owner drops req_valid mid-message, the grant is held indefinitely (unless the optional feature is enabled).
- NUM_REQ=1: the block degenerates to a pass-through. rr_ptr stays 0.
- Reset mid-message: the grant is lost. The requester restarts its message after reset.

Optional Feature:
- Macro: UART_TX_ARBITER_HOLD_TIMEOUT_EN.
- When defined:
  - A stall counter in GRANTED counts cycles with req_valid[g]=0 and clears on every accept.
  - When it reaches HOLD_TIMEOUT: grant<=0, rr_ptr<=g+1, go to IDLE.
  - A sticky output hold_timeout (1 bit, reset 0) is set.
- When undefined: there is no counter, no hold_timeout port, and a stalled owner keeps the grant.

Decomposition:
- Package uart_tx_arbiter_pkg holds:
  - the state enum (IDLE, GRANTED, START, WAIT_BUSY, WAIT_DONE);
  - the constant MAX_REQ=8;
  - the function rr_next(ptr, n).
- One combinational sub-module, uart_tx_arbiter_rr_pick: takes the valid vector and rr_ptr, returns a one-hot pick and its index. It is reused by later arbiters.

Test Plan:
- Single message: requester 0 sends "Hi" with last on 'i' → tx_data 0x48 then 0x69, two tx_start pulses, grant returns to 0, bytes_sent=2.
- Contention: requesters 1 and 2 both valid from reset → 1 served first (rr_ptr=0). After 1's last byte, 2 is granted after exactly one IDLE cycle. rr_ptr ends at 3.
- No interleave: requester 3 asserts valid mid-message of requester 0 → req_ready[3] stays 0 until requester 0's last byte completes.
- Reset mid-message: rst_n low during WAIT_DONE → next cycle grant=0, tx_start=0, bytes_sent=0. Re-arbitration starts from index 0.
- Stalled owner: with the macro and HOLD_TIMEOUT=50, the owner drops valid → grant revoked on idle cycle 50 and hold_timeout=1. Without the macro, the grant is still held after 1000 cycles.
- Counter wrap: CNT_W=4, send 17 bytes → bytes_sent=1.
